// File: rtl/b08_result_packer.sv
// b08_result_packer: collects 4-bit result nibbles from the b08 core, pairs
// them into bytes (first nibble in the low half) and queues the bytes in a
// small FIFO read through a valid/ready interface. A lone nibble can be
// flushed out with a zero upper half. Overflow is sticky until cleared.
module b08_result_packer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [3:0]    O_IN,
  input  logic          O_VALID,
  input  logic          FLUSH,
  output logic [7:0]    DOUT,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic [AW:0]   COUNT,
  output logic          PENDING,
  output logic          OVF,
  input  logic          OVF_CLR
);

  typedef enum logic [0:0] {
    EMPTY_H = 1'b0,
    HALF    = 1'b1
  } pack_state_t;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  pack_state_t     state_r;
  pack_state_t     state_next_s;
  logic [3:0]      hold_r;
  logic [3:0]      hold_next_s;
  logic            push_s;
  logic [7:0]      push_data_s;

  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_next_s;
  logic [AW-1:0]   rd_ptr_next_s;
  logic [AW:0]     count_r;
  logic [AW:0]     count_next_s;
  logic [7:0]      dout_r;
  logic [7:0]      dout_next_s;
  logic            dout_valid_r;
  logic            ovf_r;
  logic            ovf_next_s;

  logic            pop_s;
  logic            full_s;
  logic            wr_accept_s;
  logic            drop_s;

  // Packer: pair nibbles into bytes; a valid nibble always beats a flush.
  always_comb begin
    state_next_s = state_r;
    hold_next_s  = hold_r;
    push_s       = 1'b0;
    push_data_s  = 8'h00;
    case (state_r)
      EMPTY_H: begin
        if (O_VALID) begin
          hold_next_s  = O_IN;
          state_next_s = HALF;
        end else begin
          state_next_s = EMPTY_H;
        end
      end
      HALF: begin
        if (O_VALID) begin
          push_s       = 1'b1;
          push_data_s  = {O_IN, hold_r};
          state_next_s = EMPTY_H;
        end else if (FLUSH) begin
          push_s       = 1'b1;
          push_data_s  = {4'h0, hold_r};
          state_next_s = EMPTY_H;
        end else begin
          state_next_s = HALF;
        end
      end
      default: begin
        state_next_s = EMPTY_H;
      end
    endcase
  end

  // FIFO control: accept/drop decision, pointer and count update, next head byte.
  always_comb begin
    pop_s         = dout_valid_r & DOUT_READY;
    full_s        = (count_r == DEPTH_C);
    wr_accept_s   = 1'b0;
    drop_s        = 1'b0;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    ovf_next_s    = ovf_r;
    dout_next_s   = dout_r;

    if (push_s) begin
      if (!full_s || pop_s) begin
        wr_accept_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      wr_accept_s = 1'b0;
    end

    if (wr_accept_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    count_next_s = count_r + {{AW{1'b0}}, wr_accept_s} - {{AW{1'b0}}, pop_s};

    // The byte being written becomes the head when the FIFO is otherwise empty.
    if (wr_accept_s && (wr_ptr_r == rd_ptr_next_s)) begin
      dout_next_s = push_data_s;
    end else begin
      dout_next_s = mem_r[rd_ptr_next_s];
    end

    // A drop in the same cycle outranks a clear request.
    if (drop_s) begin
      ovf_next_s = 1'b1;
    end else if (OVF_CLR) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_r      <= EMPTY_H;
      hold_r       <= 4'h0;
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {(AW+1){1'b0}};
      dout_r       <= 8'h00;
      dout_valid_r <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      hold_r       <= hold_next_s;
      wr_ptr_r     <= wr_ptr_next_s;
      rd_ptr_r     <= rd_ptr_next_s;
      count_r      <= count_next_s;
      dout_r       <= dout_next_s;
      dout_valid_r <= (count_next_s != {(AW+1){1'b0}});
      ovf_r        <= ovf_next_s;
    end
  end

  // Byte storage; contents are meaningless unless covered by the count.
  always_ff @(posedge CLOCK) begin
    if (RESET && wr_accept_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  assign DOUT       = dout_r;
  assign DOUT_VALID = dout_valid_r;
  assign COUNT      = count_r;
  assign PENDING    = (state_r == HALF);
  assign OVF        = ovf_r;

endmodule

// File: tb/tb_b08_result_packer.sv
// Self-checking bench for b08_result_packer: scoreboard queue of expected
// bytes, filled when a push is driven and drained when the reader pops.
module tb_b08_result_packer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic [3:0]    O_IN;
  logic          O_VALID;
  logic          FLUSH;
  logic [7:0]    DOUT;
  logic          DOUT_VALID;
  logic          DOUT_READY;
  logic [AW:0]   COUNT;
  logic          PENDING;
  logic          OVF;
  logic          OVF_CLR;

  int            n_cmp = 0;
  int            n_err = 0;

  logic [7:0]    sb[$];
  int            m_count;
  logic          m_pend;
  logic [3:0]    m_hold;
  logic          m_ovf;

  b08_result_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .O_IN       (O_IN),
    .O_VALID    (O_VALID),
    .FLUSH      (FLUSH),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .COUNT      (COUNT),
    .PENDING    (PENDING),
    .OVF        (OVF),
    .OVF_CLR    (OVF_CLR)
  );

  always #5 CLOCK = ~CLOCK;

  // One clock cycle of stimulus; inputs change and outputs are sampled on the falling edge.
  task automatic step(input logic v, input logic [3:0] n, input logic f,
                      input logic r, input logic c);
    logic       pop;
    logic       push;
    logic       acc;
    logic       drop;
    logic [7:0] b;
    logic [7:0] exp_b;
    O_VALID = v; O_IN = n; FLUSH = f; DOUT_READY = r; OVF_CLR = c;
    pop = r && (m_count > 0);
    if (pop) begin
      exp_b = sb.pop_front();
      n_cmp++;
      if (DOUT !== exp_b || DOUT_VALID !== 1'b1) begin
        n_err++;
        $display("FAIL pop_data: DOUT=%h valid=%b, expected %h valid=1", DOUT, DOUT_VALID, exp_b);
      end
    end
    push = m_pend && (v || f);
    b    = v ? {n, m_hold} : {4'h0, m_hold};
    if (!m_pend && v) begin
      m_hold = n;
      m_pend = 1'b1;
    end else if (push) begin
      m_pend = 1'b0;
    end
    acc = 1'b0; drop = 1'b0;
    if (push) begin
      if (m_count < DEPTH || pop) begin
        sb.push_back(b);
        acc = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_count = m_count + int'(acc) - int'(pop);
    @(posedge CLOCK);
    @(negedge CLOCK);
    O_VALID = 1'b0; FLUSH = 1'b0; DOUT_READY = 1'b0; OVF_CLR = 1'b0; O_IN = 4'h0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b1;
    sb.delete();
    m_count = 0; m_pend = 1'b0; m_hold = 4'h0; m_ovf = 1'b0;
  endtask

  task automatic drain(output int popped);
    popped = 0;
    for (int k = 0; k < 2*DEPTH + 4 && m_count > 0; k++) begin
      step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      popped++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    @(posedge CLOCK);
    do_reset();
    n_cmp++;
    if ({COUNT, DOUT_VALID, DOUT, PENDING, OVF} !== {4'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: count=%0d valid=%b dout=%h pend=%b ovf=%b, expected all zero",
               COUNT, DOUT_VALID, DOUT, PENDING, OVF);
    end
  endtask

  task automatic test_pair();
    int popped;
    step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (PENDING !== 1'b1 || COUNT !== 4'd0) begin
      n_err++;
      $display("FAIL pair_first: pend=%b count=%0d, expected pend=1 count=0", PENDING, COUNT);
    end
    step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (PENDING !== 1'b0 || COUNT !== 4'd1 || DOUT !== 8'hA3 || DOUT_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL pair_byte: pend=%b count=%0d dout=%h valid=%b, expected 0 1 a3 1",
               PENDING, COUNT, DOUT, DOUT_VALID);
    end
    drain(popped);
    n_cmp++;
    if (COUNT !== 4'd0 || DOUT_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL pair_drain: count=%0d valid=%b, expected 0 0", COUNT, DOUT_VALID);
    end
  endtask

  task automatic test_flush();
    int popped;
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (DOUT !== 8'h05 || COUNT !== 4'd1 || PENDING !== 1'b0) begin
      n_err++;
      $display("FAIL flush_byte: dout=%h count=%0d pend=%b, expected 05 1 0", DOUT, COUNT, PENDING);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (COUNT !== 4'd1 || PENDING !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: count=%0d pend=%b, expected 1 0", COUNT, PENDING);
    end
    drain(popped);
  endtask

  task automatic test_flush_and_valid();
    int popped;
    step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (COUNT !== 4'd1 || DOUT !== 8'hF1 || PENDING !== 1'b0) begin
      n_err++;
      $display("FAIL flush_valid: count=%0d dout=%h pend=%b, expected 1 f1 0", COUNT, DOUT, PENDING);
    end
    drain(popped);
    n_cmp++;
    if (popped !== 1 || COUNT !== 4'd0) begin
      n_err++;
      $display("FAIL flush_valid_single: popped=%0d count=%0d, expected 1 0", popped, COUNT);
    end
  endtask

  task automatic test_pushpop_one();
    int popped;
    step(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (COUNT !== 4'd1 || DOUT !== 8'h76 || DOUT_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL pushpop_one: count=%0d dout=%h valid=%b, expected 1 76 1", COUNT, DOUT, DOUT_VALID);
    end
    drain(popped);
  endtask

  task automatic test_overflow();
    int popped;
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'(15 - i), 1'b0, 1'b0, 1'b0);
    end
    n_cmp++;
    if (COUNT !== 4'd8 || OVF !== 1'b1 || DOUT !== 8'hF0 || PENDING !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_full: count=%0d ovf=%b dout=%h pend=%b, expected 8 1 f0 0",
               COUNT, OVF, DOUT, PENDING);
    end
    drain(popped);
    n_cmp++;
    if (popped !== DEPTH || COUNT !== 4'd0 || DOUT_VALID !== 1'b0 || OVF !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_drain: popped=%0d count=%0d valid=%b ovf=%b, expected 8 0 0 1",
               popped, COUNT, DOUT_VALID, OVF);
    end
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (OVF !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: ovf=%b, expected 0", OVF);
    end
  endtask

  task automatic test_full_pushpop();
    int popped;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 4'(i + 3), 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'(i + 8), 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (COUNT !== 4'd8 || OVF !== 1'b0 || PENDING !== 1'b0 || DOUT !== 8'h94) begin
      n_err++;
      $display("FAIL full_pushpop: count=%0d ovf=%b pend=%b dout=%h, expected 8 0 0 94",
               COUNT, OVF, PENDING, DOUT);
    end
    drain(popped);
    n_cmp++;
    if (popped !== DEPTH || COUNT !== 4'd0 || DOUT_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL full_pushpop_drain: popped=%0d count=%0d valid=%b, expected 8 0 0",
               popped, COUNT, DOUT_VALID);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (COUNT !== 4'd5 || PENDING !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: count=%0d pend=%b, expected 5 1", COUNT, PENDING);
    end
    do_reset();
    n_cmp++;
    if ({COUNT, DOUT_VALID, DOUT, PENDING, OVF} !== {4'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: count=%0d valid=%b dout=%h pend=%b ovf=%b, expected all zero",
               COUNT, DOUT_VALID, DOUT, PENDING, OVF);
    end
    step(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (COUNT !== 4'd1 || DOUT !== 8'h87) begin
      n_err++;
      $display("FAIL post_reset: count=%0d dout=%h, expected 1 87", COUNT, DOUT);
    end
  endtask

  task automatic test_back_to_back();
    int popped;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'(2*i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'(2*i + 1), 1'b0, 1'b1, 1'b0);
    end
    drain(popped);
    n_cmp++;
    if (COUNT !== 4'd0 || DOUT_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back: count=%0d valid=%b, expected 0 0", COUNT, DOUT_VALID);
    end
  endtask

  initial begin
    RESET = 1'b0; O_IN = 4'h0; O_VALID = 1'b0; FLUSH = 1'b0;
    DOUT_READY = 1'b0; OVF_CLR = 1'b0;
    sb.delete();
    m_count = 0; m_pend = 1'b0; m_hold = 4'h0; m_ovf = 1'b0;
    @(negedge CLOCK);
    test_reset();
    test_pair();
    test_flush();
    test_flush_and_valid();
    test_pushpop_one();
    test_overflow();
    test_full_pushpop();
    test_reset_midstream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
